// File: rtl/rate_enb_multi.sv
// Multi-channel rate enable generator: each channel emits single-cycle enable
// pulses either periodically (while run is high) or once per trigger (one-shot).
module rate_enb_multi #(
  parameter int NCH     = 4,
  parameter int DIVW    = 16,
  parameter int RATE_HZ = 9600,
  parameter int CLKFREQ = 100_000_000,
  localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NCH-1:0]  clr,
  input  logic [NCH-1:0]  run,
  input  logic [NCH-1:0]  trig,
  input  logic            wr_en,
  input  logic [CHW-1:0]  wr_ch,
  input  logic [DIVW-1:0] wr_div,
  input  logic            wr_mode,
  output logic [NCH-1:0]  enb_out,
  output logic [NCH-1:0]  busy,
  output logic            wr_err
);

  localparam int              DEF_DIV   = CLKFREQ / RATE_HZ;
  localparam logic [DIVW-1:0] DEF_DIV_L = DIVW'(DEF_DIV);
  localparam logic [DIVW-1:0] ONE       = DIVW'(1);
  localparam logic [CHW:0]    NCH_L     = (CHW+1)'(NCH);

  if (DEF_DIV < 1 || longint'(DEF_DIV) >= (longint'(1) << DIVW)) begin : g_bad_def_div
    $error("rate_enb_multi: CLKFREQ/RATE_HZ does not fit a nonzero DIVW-bit divisor");
  end

  logic [DIVW-1:0] cnt_q [NCH];
  logic [DIVW-1:0] cnt_d [NCH];
  logic [DIVW-1:0] div_q [NCH];
  logic [DIVW-1:0] div_d [NCH];
  logic [NCH-1:0]  mode_q, mode_d;
  logic [NCH-1:0]  busy_q, busy_d;
  logic [NCH-1:0]  enb_q, enb_d;
  logic            wr_err_q, wr_err_d;

  logic            wrValid;
  logic [NCH-1:0]  wrHit;
  logic [NCH-1:0]  atTerm;

  // A write is only accepted for an existing channel and a nonzero divisor.
  always_comb begin
    wrValid = wr_en && (wr_div != '0) && ({1'b0, wr_ch} < NCH_L);
    wr_err_d = wr_en && !wrValid;
    wrHit = '0;
    for (int i = 0; i < NCH; i++) begin
      wrHit[i] = wrValid && (wr_ch == CHW'(i));
    end
  end

  // Terminal compare uses >= so a stray count can never run past div-1.
  always_comb begin
    atTerm = '0;
    for (int i = 0; i < NCH; i++) begin
      atTerm[i] = (cnt_q[i] >= (div_q[i] - ONE));
    end
  end

  // Per-channel next state: write beats clear, clear beats counting/trigger.
  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    mode_d = mode_q;
    busy_d = busy_q;
    enb_d  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (wrHit[i]) begin
        div_d[i]  = wr_div;
        mode_d[i] = wr_mode;
        cnt_d[i]  = '0;
        busy_d[i] = 1'b0;
      end else if (clr[i]) begin
        cnt_d[i]  = '0;
        busy_d[i] = 1'b0;
      end else if (!mode_q[i]) begin
        if (run[i]) begin
          if (atTerm[i]) begin
            cnt_d[i] = '0;
            enb_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + ONE;
          end
        end
      end else if (busy_q[i]) begin
        if (atTerm[i]) begin
          cnt_d[i]  = '0;
          busy_d[i] = 1'b0;
          enb_d[i]  = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + ONE;
        end
      end else if (trig[i]) begin
        cnt_d[i]  = '0;
        busy_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
        div_q[i] <= DEF_DIV_L;
      end
      mode_q   <= '0;
      busy_q   <= '0;
      enb_q    <= '0;
      wr_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
        div_q[i] <= div_d[i];
      end
      mode_q   <= mode_d;
      busy_q   <= busy_d;
      enb_q    <= enb_d;
      wr_err_q <= wr_err_d;
    end
  end

  assign enb_out = enb_q;
  assign busy    = busy_q;
  assign wr_err  = wr_err_q;

endmodule

// File: tb/tb_rate_enb_multi.sv
// Directed bench for rate_enb_multi: periodic, one-shot, config writes,
// clear priority and asynchronous reset, with hand-computed expectations.
module tb_rate_enb_multi;

  localparam int NCH  = 5;
  localparam int CHW  = 3;
  localparam int DIVW = 16;
  localparam int DEF  = 10416;

  logic            clk;
  logic            rst_n;
  logic [NCH-1:0]  clr, run, trig;
  logic            wr_en;
  logic [CHW-1:0]  wr_ch;
  logic [DIVW-1:0] wr_div;
  logic            wr_mode;
  logic [NCH-1:0]  enb_out, busy;
  logic            wr_err;

  int checks = 0;
  int errors = 0;

  rate_enb_multi #(.NCH(NCH), .DIVW(DIVW)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .run(run), .trig(trig),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div), .wr_mode(wr_mode),
    .enb_out(enb_out), .busy(busy), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives the per-channel controls for one clock, then samples 1ns after the edge.
  task automatic applyStimulus(input logic [NCH-1:0] c, input logic [NCH-1:0] r, input logic [NCH-1:0] t);
    clr  = c;
    run  = r;
    trig = t;
    @(posedge clk);
    #1;
  endtask

  task automatic writeCfg(input logic [CHW-1:0] ch, input logic [DIVW-1:0] d, input logic m,
                          input logic [NCH-1:0] c, input logic [NCH-1:0] r);
    wr_en   = 1'b1;
    wr_ch   = ch;
    wr_div  = d;
    wr_mode = m;
    applyStimulus(c, r, '0);
    wr_en   = 1'b0;
  endtask

  task automatic waitPulse(input int ch, input int n, input string tag);
    int early;
    logic [NCH-1:0] r;
    early = 0;
    r = NCH'(1) << ch;
    for (int k = 0; k < n - 1; k++) begin
      applyStimulus('0, r, '0);
      if (enb_out[ch]) early++;
    end
    checkOutput({tag, " early"}, early, 0);
    applyStimulus('0, r, '0);
    checkOutput(tag, enb_out[ch], 1);
    checkOutput({tag, " others"}, enb_out & ~r, 0);
  endtask

  initial begin
    logic [15:0] v, vb;
    clk = 0; rst_n = 0;
    clr = '0; run = '0; trig = '0;
    wr_en = 0; wr_ch = '0; wr_div = '0; wr_mode = 0;
    #12;
    checkOutput("reset enb", enb_out, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset wr_err", wr_err, 0);
    rst_n = 1;
    @(posedge clk);
    #1;

    $display("[TB] default divisor on ch0");
    waitPulse(0, DEF, "ch0 first pulse");
    waitPulse(0, DEF, "ch0 period");
    applyStimulus('0, '0, '0);

    $display("[TB] ch1 periodic D=5 with pause");
    writeCfg(1, 5, 0, '0, '0);
    checkOutput("wr ok ch1", wr_err, 0);
    v = '0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus('0, 5'b00010, '0);
      v[k] = enb_out[1];
    end
    checkOutput("ch1 period5", v, 16'b0000_0010_0001_0000);
    v = '0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus('0, (k >= 2 && k <= 4) ? 5'b00000 : 5'b00010, '0);
      v[k] = enb_out[1];
    end
    checkOutput("ch1 paused period8", v, 16'b0000_0000_1000_0000);

    $display("[TB] ch2 one-shot D=4");
    writeCfg(2, 4, 1, '0, '0);
    applyStimulus('0, 5'b00100, 5'b00100);
    checkOutput("ch2 busy at trig", busy[2], 1);
    checkOutput("ch2 enb at trig", enb_out[2], 0);
    v = '0; vb = '0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus('0, 5'b00100, (k == 1) ? 5'b00100 : 5'b00000);
      vb[k] = busy[2];
      v[k]  = enb_out[2];
    end
    checkOutput("ch2 busy seq", vb, 16'b0000_0000_0000_0111);
    checkOutput("ch2 enb seq", v, 16'b0000_0000_0000_1000);

    $display("[TB] rejected writes");
    writeCfg(2, 0, 0, '0, '0);
    checkOutput("wr_err div0", wr_err, 1);
    applyStimulus('0, '0, '0);
    checkOutput("wr_err div0 drop", wr_err, 0);
    writeCfg(3'd5, 7, 0, '0, '0);
    checkOutput("wr_err bad ch", wr_err, 1);
    applyStimulus('0, '0, '0);
    checkOutput("wr_err bad ch drop", wr_err, 0);
    v = '0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus('0, 5'b00010, '0);
      v[k] = enb_out[1];
    end
    checkOutput("ch1 kept D5", v, 16'b0000_0000_0001_0000);
    applyStimulus('0, '0, 5'b00100);
    checkOutput("ch2 kept oneshot", busy[2], 1);
    v = '0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus('0, '0, '0);
      v[k] = enb_out[2];
    end
    checkOutput("ch2 kept D4", v, 16'b0000_0000_0000_1000);

    $display("[TB] ch3 D=1 and clear priority");
    writeCfg(3, 1, 0, '0, '0);
    v = '0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus('0, 5'b01000, '0);
      v[k] = enb_out[3];
    end
    checkOutput("ch3 always high", v, 16'b0000_0000_0000_0111);
    applyStimulus(5'b01000, 5'b01000, '0);
    checkOutput("ch3 clr kills pulse", enb_out[3], 0);
    applyStimulus('0, 5'b01000, '0);
    checkOutput("ch3 resumes", enb_out[3], 1);
    writeCfg(1, 3, 0, 5'b00010, 5'b00010);
    checkOutput("ch1 clr+wr enb", enb_out[1], 0);
    checkOutput("ch1 clr+wr err", wr_err, 0);
    v = '0;
    for (int k = 0; k < 6; k++) begin
      applyStimulus('0, 5'b00010, '0);
      v[k] = enb_out[1];
    end
    checkOutput("ch1 new D3", v, 16'b0000_0000_0010_0100);

    $display("[TB] async reset mid one-shot");
    applyStimulus('0, 5'b01000, 5'b00100);
    applyStimulus('0, 5'b01000, '0);
    checkOutput("pre-reset busy2", busy[2], 1);
    checkOutput("pre-reset enb3", enb_out[3], 1);
    #2;
    rst_n = 0;
    #1;
    checkOutput("async reset enb", enb_out, 0);
    checkOutput("async reset busy", busy, 0);
    run = '0;
    #1;
    rst_n = 1;
    @(posedge clk);
    #1;
    applyStimulus('0, '0, 5'b00100);
    checkOutput("post-reset ch2 periodic", busy[2], 0);
    waitPulse(1, DEF, "ch1 default after reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rate_enb_multi.md
RATE_ENB_MULTI -- requirements
Module: rate_enb_multi

Interface
REQ-001 SHALL have parameter NCH, default 4: number of independent enable channels (1..16).
REQ-002 SHALL have parameter DIVW, default 16: width of each channel's divisor and counter.
REQ-003 SHALL have parameter RATE_HZ, default 9600: rate used to derive the reset divisor.
REQ-004 SHALL have parameter CLKFREQ, default 100_000_000: clock frequency in Hz.
REQ-005 SHALL define localparam DEF_DIV = CLKFREQ/RATE_HZ (10416 at defaults), and elaboration SHALL fail if DEF_DIV < 1 or DEF_DIV >= 2**DIVW.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low master reset.
REQ-008 SHALL have port clr, input, NCH bits: per-channel synchronous clear.
REQ-009 SHALL have port run, input, NCH bits: per-channel count enable (periodic mode).
REQ-010 SHALL have port trig, input, NCH bits: per-channel start request (one-shot mode).
REQ-011 SHALL have port wr_en, input, 1 bit: configuration write strobe.
REQ-012 SHALL have port wr_ch, input, max(1,$clog2(NCH)) bits: target channel of the write.
REQ-013 SHALL have port wr_div, input, DIVW bits: new divisor D.
REQ-014 SHALL have port wr_mode, input, 1 bit: new mode (0 periodic, 1 one-shot).
REQ-015 SHALL have port enb_out, output, NCH bits: registered single-cycle enable pulses.
REQ-016 SHALL have port busy, output, NCH bits: one-shot timing in progress.
REQ-017 SHALL have port wr_err, output, 1 bit: registered one-cycle pulse flagging a rejected write.

Function
REQ-018 SHALL keep per channel a counter q, divisor div_r, mode_r and busy flag; channels SHALL be fully independent.
REQ-019 Periodic mode: each edge with run[i]=1 SHALL increment q, except q==div_r-1, which SHALL load q=0 and set enb_out[i]=1 for the next cycle.
REQ-020 Periodic mode: run[i]=0 SHALL hold q (pause, not clear) and drive enb_out[i]=0; period SHALL be exactly div_r cycles while run is held high.
REQ-021 Periodic mode, div_r=1: enb_out[i] SHALL be high on every cycle following an edge with run[i]=1.
REQ-022 One-shot mode: trig[i] sampled with busy[i]=0 SHALL clear q and set busy[i]=1; q SHALL count every edge irrespective of run.
REQ-023 One-shot mode: at trigger edge k, enb_out[i] SHALL be high for exactly one cycle after edge k+div_r, with busy[i] cleared at that same edge (busy high div_r cycles).
REQ-024 One-shot mode: trig while busy SHALL be ignored (no retrigger); trig in periodic mode and run in one-shot mode SHALL be ignored.
REQ-025 A write with wr_en=1, wr_div!=0 and wr_ch<NCH SHALL load div_r/mode_r, clear q and busy, and suppress that channel's pulse on that edge.
REQ-026 A write with wr_div=0 or wr_ch>=NCH SHALL change no state and SHALL pulse wr_err for one cycle.
REQ-027 clr[i]=1 SHALL clear q and busy[i] and force enb_out[i]=0 next cycle, overriding terminal count, trig and run on the same edge.
REQ-028 clr[i] and a valid write to channel i on the same edge SHALL both take effect (new divisor loaded, q=0, busy=0).
REQ-029 Counter arithmetic SHALL be DIVW-bit unsigned; q SHALL never exceed div_r-1.

Reset
REQ-030 rst_n=0 SHALL asynchronously set all q=0, div_r=DEF_DIV, mode_r=0, busy=0, enb_out=0, wr_err=0, including mid-count or mid-one-shot.
REQ-031 After rst_n deasserts, counting SHALL start only on the first edge with run or trig sampled high.

Verification
REQ-032 Reset then run[0]=1 held, defaults: enb_out[0] pulses every 10416 cycles, first pulse after the 10416th edge; other channels stay 0.
REQ-033 Write ch1 D=5 mode=0, run[1]=1: pulses every 5 cycles; run[1] low 3 cycles mid-period extends that period to 8.
REQ-034 Write ch2 D=4 mode=1, trig pulse: busy[2] high 4 cycles, then a single enb_out[2] pulse; trig during busy ignored.
REQ-035 Write D=0, then wr_ch=NCH: wr_err pulses once each; all channel configurations unchanged.
REQ-036 Ch3 D=1 periodic: enb_out[3] continuously high; clr[3] asserted on a terminal-count cycle yields enb_out[3]=0 next cycle.
REQ-037 rst_n low mid one-shot: busy and enb_out drop immediately without waiting for a clock edge; div_r reads back as DEF_DIV behaviour.
